// File: rtl/sram_scan_sequencer.sv
// sram_scan_sequencer
//   Raster-scans the graylevel image in the single-port image SRAM. It builds a TAPS-wide
//   sliding window of pixels along linear addresses and presents it to the filter datapath
//   over a valid/ready handshake. This block owns the SRAM address bus.
//
// Optional feature: define PEEK_PORT_EN to add a single-pixel peek port. The peek port
//   shares the SRAM and has lower priority than the scan.
//
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   start        begin a scan (honoured only in idle)
//   busy         high in every state except idle
//   done         one-cycle pulse after the last window handshake
//   sram_addr    SRAM address; read data returns on sram_rdata one cycle later
//   sram_rdata   SRAM read data
//   win_valid    win_data/win_center hold a valid window
//   win_ready    datapath accepts the window
//   win_data     TAPS pixels; oldest (center-HALF) in the LSBs
//   win_center   linear address of the center pixel
//   win_count    windows accepted since the last start
//   peek_*       (PEEK_PORT_EN) req/addr in, gnt out; valid/data one cycle after the grant
module sram_scan_sequencer #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_W     = 160,
  parameter int unsigned ROW_FIRST = 1,
  parameter int unsigned ROW_LAST  = 88,
  parameter int unsigned TAPS      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [DATA_W-1:0]        sram_rdata,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [TAPS*DATA_W-1:0]   win_data,
  output logic [ADDR_W-1:0]        win_center,
  output logic [15:0]              win_count
`ifdef PEEK_PORT_EN
  ,
  input  logic                     peek_req,
  input  logic [ADDR_W-1:0]        peek_addr,
  output logic                     peek_gnt,
  output logic                     peek_valid,
  output logic [DATA_W-1:0]        peek_data
`endif
);

  localparam int unsigned HALF   = TAPS / 2;
  localparam int unsigned C0     = ROW_FIRST * IMG_W;
  localparam int unsigned C1     = (ROW_LAST + 1) * IMG_W - 1;
  localparam int unsigned FILL_W = $clog2(TAPS + 1);

  localparam logic [ADDR_W-1:0] C0_A    = ADDR_W'(C0);
  localparam logic [ADDR_W-1:0] C1_A    = ADDR_W'(C1);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(C0 - HALF);
  localparam logic [ADDR_W-1:0] AHEAD_A = ADDR_W'(HALF + 1);
  localparam logic [FILL_W-1:0] TAPS_F  = FILL_W'(TAPS);

  typedef enum logic [2:0] {StIdle, StFill, StPresent, StFetch, StShift, StDone} state_e;

  state_e                   state_q, state_d;
  logic [FILL_W-1:0]        fill_cnt_q;
  logic [TAPS*DATA_W-1:0]   win_data_q;
  logic [ADDR_W-1:0]        win_center_q;
  logic [15:0]              win_count_q;
  logic                     scan_pend_q;
  logic                     scan_issue;
  logic [ADDR_W-1:0]        scan_addr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFill;
      StFill:    if (fill_cnt_q == TAPS_F) state_d = StPresent;
      StPresent: if (win_ready) state_d = (win_center_q == C1_A) ? StDone : StFetch;
      StFetch:   state_d = StShift;
      StShift:   state_d = StPresent;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs and scan read issue
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    win_valid  = (state_q == StPresent);
    scan_issue = 1'b0;
    scan_addr  = '0;
    unique case (state_q)
      StFill: begin
        // Last FILL cycle only captures; it issues nothing.
        if (fill_cnt_q < TAPS_F) begin
          scan_issue = 1'b1;
          scan_addr  = FIRST_A + ADDR_W'(fill_cnt_q);
        end
      end
      StFetch: begin
        scan_issue = 1'b1;
        scan_addr  = win_center_q + AHEAD_A;
      end
      default: ;
    endcase
  end

  // Window datapath. scan_pend_q marks that this cycle's sram_rdata answers a scan read,
  // so peek data never reaches the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt_q   <= '0;
      win_data_q   <= '0;
      win_center_q <= '0;
      win_count_q  <= '0;
      scan_pend_q  <= 1'b0;
    end else begin
      scan_pend_q <= scan_issue;
      if (state_q == StIdle && start) begin
        fill_cnt_q   <= '0;
        win_count_q  <= '0;
        win_center_q <= C0_A;
      end
      if (state_q == StFill) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (scan_pend_q) win_data_q <= {sram_rdata, win_data_q[TAPS*DATA_W-1:DATA_W]};
      if (state_q == StPresent && win_ready) win_count_q <= win_count_q + 16'd1;
      if (state_q == StShift) win_center_q <= win_center_q + 1'b1;
    end
  end

  assign win_data   = win_data_q;
  assign win_center = win_center_q;
  assign win_count  = win_count_q;

`ifdef PEEK_PORT_EN
  logic peek_valid_q;

  assign peek_gnt  = peek_req & ~scan_issue;
  assign sram_addr = peek_gnt ? peek_addr : scan_addr;

  always_ff @(posedge clk) begin
    if (reset) peek_valid_q <= 1'b0;
    else       peek_valid_q <= peek_gnt;
  end

  assign peek_valid = peek_valid_q;
  assign peek_data  = peek_valid_q ? sram_rdata : '0;
`else
  assign sram_addr = scan_addr;
`endif

endmodule
